// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: frame FSM encoding,
// the scan codes that get special handling, and the set-2 letter lookup.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } frame_state_t;

    localparam logic [7:0] KEY_EXT     = 8'hE0;
    localparam logic [7:0] KEY_BRK     = 8'hF0;
    localparam logic [7:0] KEY_ENTER   = 8'h5A;
    localparam logic [7:0] KEY_BKSP    = 8'h66;
    localparam logic [4:0] LETTER_NONE = 5'd31;

    function automatic logic [4:0] letter_of(input logic [7:0] code);
        logic [4:0] letter;
        case (code)
            8'h1C: letter = 5'd0;
            8'h32: letter = 5'd1;
            8'h21: letter = 5'd2;
            8'h23: letter = 5'd3;
            8'h24: letter = 5'd4;
            8'h2B: letter = 5'd5;
            8'h34: letter = 5'd6;
            8'h33: letter = 5'd7;
            8'h43: letter = 5'd8;
            8'h3B: letter = 5'd9;
            8'h42: letter = 5'd10;
            8'h4B: letter = 5'd11;
            8'h3A: letter = 5'd12;
            8'h31: letter = 5'd13;
            8'h44: letter = 5'd14;
            8'h4D: letter = 5'd15;
            8'h15: letter = 5'd16;
            8'h2D: letter = 5'd17;
            8'h1B: letter = 5'd18;
            8'h2C: letter = 5'd19;
            8'h3C: letter = 5'd20;
            8'h2A: letter = 5'd21;
            8'h1D: letter = 5'd22;
            8'h22: letter = 5'd23;
            8'h35: letter = 5'd24;
            8'h1A: letter = 5'd25;
            default: letter = LETTER_NONE;
        endcase
        return letter;
    endfunction

endpackage

// File: rtl/ps2_filter.sv
// Two-flop synchronizer followed by a glitch filter: the output level only
// changes after FILTER_LEN consecutive samples that disagree with it.
module ps2_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic clr_n,
    input  logic i_raw,
    output logic o_level
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_level;

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_sync  <= 2'b11;
            r_cnt   <= '0;
            r_level <= 1'b1;
        end else begin
            r_sync <= {r_sync[0], i_raw};
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
                r_level <= r_sync[1];
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: deframes 11-bit frames, tracks E0/F0 prefixes and
// reports make events with letter / Enter / Backspace decoding.
module ps2_key_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic [4:0] key_letter,
    output logic       key_enter,
    output logic       key_bksp,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic w_clk_f;
    logic w_data_f;
    logic w_fall;

    ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk     (clk),
        .clr_n   (clr_n),
        .i_raw   (ps2_clk),
        .o_level (w_clk_f)
    );

    ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk     (clk),
        .clr_n   (clr_n),
        .i_raw   (ps2_data),
        .o_level (w_data_f)
    );

    frame_state_t  r_state;
    logic          r_clk_prev;
    logic [7:0]    r_shift;
    logic [2:0]    r_bit_cnt;
    logic          r_parity;
    logic [TW-1:0] r_timeout;
    logic          r_ext;
    logic          r_brk;
    logic          r_key_valid;
    logic          r_frame_err;
    logic [7:0]    r_key_code;
    logic [4:0]    r_key_letter;
    logic          r_key_enter;
    logic          r_key_bksp;

    assign w_fall = r_clk_prev & ~w_clk_f;

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_state      <= ST_IDLE;
            r_clk_prev   <= 1'b1;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_parity     <= 1'b0;
            r_timeout    <= '0;
            r_ext        <= 1'b0;
            r_brk        <= 1'b0;
            r_key_valid  <= 1'b0;
            r_frame_err  <= 1'b0;
            r_key_code   <= 8'h00;
            r_key_letter <= LETTER_NONE;
            r_key_enter  <= 1'b0;
            r_key_bksp   <= 1'b0;
        end else begin
            r_clk_prev  <= w_clk_f;
            r_key_valid <= 1'b0;
            r_frame_err <= 1'b0;

            if (r_state == ST_IDLE || w_fall) r_timeout <= '0;
            else                              r_timeout <= r_timeout + 1'b1;

            case (r_state)
                ST_IDLE: if (w_fall) begin
                    if (!w_data_f) begin
                        r_state   <= ST_DATA;
                        r_bit_cnt <= '0;
                    end else begin
                        r_frame_err <= 1'b1;
                    end
                end
                ST_DATA: if (w_fall) begin
                    r_shift   <= {w_data_f, r_shift[7:1]};
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                    if (r_bit_cnt == 3'd7) r_state <= ST_PARITY;
                end
                ST_PARITY: if (w_fall) begin
                    r_parity <= w_data_f;
                    r_state  <= ST_STOP;
                end
                ST_STOP: if (w_fall) begin
                    r_state <= ST_IDLE;
                    // Good frame: stop bit high and odd parity over data+parity.
                    if (w_data_f && (^{r_shift, r_parity})) begin
                        case (r_shift)
                            KEY_EXT: r_ext <= 1'b1;
                            KEY_BRK: r_brk <= 1'b1;
                            default: begin
                                r_ext <= 1'b0;
                                r_brk <= 1'b0;
                                if (!r_brk) begin
                                    r_key_valid  <= 1'b1;
                                    r_key_code   <= r_shift;
                                    r_key_letter <= r_ext ? LETTER_NONE : letter_of(r_shift);
                                    r_key_enter  <= !r_ext && (r_shift == KEY_ENTER);
                                    r_key_bksp   <= !r_ext && (r_shift == KEY_BKSP);
                                end
                            end
                        endcase
                    end else begin
                        r_frame_err <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // Stalled keyboard clock: abandon the partial frame.
            if (r_state != ST_IDLE && !w_fall && r_timeout == TW'(TIMEOUT_CYCLES - 1)) begin
                r_state     <= ST_IDLE;
                r_frame_err <= 1'b1;
            end
        end
    end

    assign key_valid  = r_key_valid;
    assign key_code   = r_key_code;
    assign key_letter = r_key_letter;
    assign key_enter  = r_key_enter;
    assign key_bksp   = r_key_bksp;
    assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_ps2_key_rx.sv
// Directed bench for ps2_key_rx: bit-bangs PS/2 frames and compares outputs
// and pulse counts against hand-computed values.
module tb_ps2_key_rx;

    logic       clk;
    logic       clr_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic       key_valid;
    logic [7:0] key_code;
    logic [4:0] key_letter;
    logic       key_enter;
    logic       key_bksp;
    logic       frame_err;

    int checks   = 0;
    int failures = 0;
    int n_valid  = 0;
    int n_err    = 0;
    int n_both   = 0;
    int v0;
    int e0;

    ps2_key_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(5000)) dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .key_letter (key_letter),
        .key_enter  (key_enter),
        .key_bksp   (key_bksp),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Count high cycles of each pulse output, sampled away from the active edge.
    always @(negedge clk) begin
        if (key_valid === 1'b1) n_valid++;
        if (frame_err === 1'b1) n_err++;
        if (key_valid === 1'b1 && frame_err === 1'b1) n_both++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ps2_bit(input logic b, input int half);
        ps2_data = b;
        repeat (half) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (half) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic ps2_frame(input logic [7:0] code, input logic bad_par, input int half);
        ps2_bit(1'b0, half);
        for (int i = 0; i < 8; i++) ps2_bit(code[i], half);
        ps2_bit((~(^code)) ^ bad_par, half);
        ps2_bit(1'b1, half);
        repeat (30) @(negedge clk);
    endtask

    task automatic snap();
        v0 = n_valid;
        e0 = n_err;
    endtask

    task automatic check_outputs(input string tag, input logic [7:0] code,
                                 input logic [4:0] letter, input logic enter, input logic bksp);
        check({tag, ".code"},   32'(key_code),   32'(code));
        check({tag, ".letter"}, 32'(key_letter), 32'(letter));
        check({tag, ".enter"},  32'(key_enter),  32'(enter));
        check({tag, ".bksp"},   32'(key_bksp),   32'(bksp));
    endtask

    initial begin
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        clr_n    = 1'b0;
        repeat (5) @(negedge clk);
        check("reset.valid", 32'(key_valid), 32'd0);
        check("reset.err",   32'(frame_err), 32'd0);
        check_outputs("reset", 8'h00, 5'd31, 1'b0, 1'b0);
        clr_n = 1'b1;
        repeat (20) @(negedge clk);

        // make: 0x1C at an 80 us keyboard clock period
        snap();
        ps2_frame(8'h1C, 1'b0, 2000);
        check("make.valid_pulses", 32'(n_valid - v0), 32'd1);
        check("make.err_pulses",   32'(n_err - e0),   32'd0);
        check_outputs("make", 8'h1C, 5'd0, 1'b0, 1'b0);

        // break: F0 1C changes nothing
        snap();
        ps2_frame(8'hF0, 1'b0, 20);
        ps2_frame(8'h1C, 1'b0, 20);
        check("break.valid_pulses", 32'(n_valid - v0), 32'd0);
        check("break.err_pulses",   32'(n_err - e0),   32'd0);
        check_outputs("break", 8'h1C, 5'd0, 1'b0, 1'b0);

        // flags cleared after the break: plain 0x32 is B
        snap();
        ps2_frame(8'h32, 1'b0, 20);
        check("after_break.valid_pulses", 32'(n_valid - v0), 32'd1);
        check_outputs("after_break", 8'h32, 5'd1, 1'b0, 1'b0);

        // extended: E0 5A is keypad Enter, not Enter
        snap();
        ps2_frame(8'hE0, 1'b0, 20);
        ps2_frame(8'h5A, 1'b0, 20);
        check("ext.valid_pulses", 32'(n_valid - v0), 32'd1);
        check_outputs("ext", 8'h5A, 5'd31, 1'b0, 1'b0);

        // plain Enter, then a typematic repeat
        snap();
        ps2_frame(8'h5A, 1'b0, 20);
        ps2_frame(8'h5A, 1'b0, 20);
        check("enter.valid_pulses", 32'(n_valid - v0), 32'd2);
        check_outputs("enter", 8'h5A, 5'd31, 1'b1, 1'b0);

        // parity error on 0x2D, then a good 0x2D
        snap();
        ps2_frame(8'h2D, 1'b1, 20);
        check("parity.err_pulses",   32'(n_err - e0),   32'd1);
        check("parity.valid_pulses", 32'(n_valid - v0), 32'd0);
        check_outputs("parity", 8'h5A, 5'd31, 1'b1, 1'b0);
        snap();
        ps2_frame(8'h2D, 1'b0, 20);
        check("after_parity.valid_pulses", 32'(n_valid - v0), 32'd1);
        check_outputs("after_parity", 8'h2D, 5'd17, 1'b0, 1'b0);

        // a data-high edge while idle is a start-bit error
        snap();
        ps2_bit(1'b1, 20);
        repeat (30) @(negedge clk);
        check("start_err.err_pulses", 32'(n_err - e0), 32'd1);

        // timeout: keyboard clock stops after 4 data bits
        snap();
        ps2_bit(1'b0, 20);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1, 20);
        ps2_data = 1'b1;
        repeat (4000) @(negedge clk);
        check("timeout.early_err", 32'(n_err - e0), 32'd0);
        repeat (1300) @(negedge clk);
        check("timeout.err_pulses",   32'(n_err - e0),   32'd1);
        check("timeout.valid_pulses", 32'(n_valid - v0), 32'd0);
        snap();
        ps2_frame(8'h66, 1'b0, 20);
        check("after_timeout.valid_pulses", 32'(n_valid - v0), 32'd1);
        check("after_timeout.err_pulses",   32'(n_err - e0),   32'd0);
        check_outputs("after_timeout", 8'h66, 5'd31, 1'b0, 1'b1);

        // 3-cycle low glitch on ps2_clk while idle must not register an edge
        snap();
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (50) @(negedge clk);
        check("glitch.err_pulses",   32'(n_err - e0),   32'd0);
        check("glitch.valid_pulses", 32'(n_valid - v0), 32'd0);

        // reset mid-frame, then a normal frame
        ps2_frame(8'h1C, 1'b0, 20);
        snap();
        ps2_bit(1'b0, 20);
        ps2_bit(1'b1, 20);
        ps2_bit(1'b0, 20);
        clr_n = 1'b0;
        repeat (3) @(negedge clk);
        check("midreset.valid", 32'(key_valid), 32'd0);
        check("midreset.err",   32'(frame_err), 32'd0);
        check_outputs("midreset", 8'h00, 5'd31, 1'b0, 1'b0);
        ps2_data = 1'b1;
        clr_n = 1'b1;
        repeat (20) @(negedge clk);
        ps2_frame(8'h2D, 1'b0, 20);
        check("after_reset.valid_pulses", 32'(n_valid - v0), 32'd1);
        check("after_reset.err_pulses",   32'(n_err - e0),   32'd0);
        check_outputs("after_reset", 8'h2D, 5'd17, 1'b0, 1'b0);

        check("no_overlap", 32'(n_both), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_key_rx.md
PS2_KEY_RX -- requirements
Module: ps2_key_rx

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8: number of consecutive identical samples needed before ps2_clk or ps2_data changes its filtered level.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 5000: maximum clk cycles between two falling edges inside one frame (100 us at 50 MHz).
REQ-003 SHALL have port clk, input, 1 bit: master clock, 50 MHz; one clock domain only.
REQ-004 SHALL have port clr_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port ps2_clk, input, 1 bit: keyboard clock, asynchronous, idles high.
REQ-006 SHALL have port ps2_data, input, 1 bit: keyboard data, asynchronous, idles high.
REQ-007 SHALL have port key_valid, output, 1 bit: one-cycle pulse marking a decoded make event.
REQ-008 SHALL have port key_code, output, 8 bits: raw scan code of the last make event.
REQ-009 SHALL have port key_letter, output, 5 bits: 0-25 for A-Z; 31 when the key is not a letter.
REQ-010 SHALL have port key_enter, output, 1 bit: last make event was Enter.
REQ-011 SHALL have port key_bksp, output, 1 bit: last make event was Backspace.
REQ-012 SHALL have port frame_err, output, 1 bit: one-cycle pulse on a parity, start, stop or timeout error.

Function
REQ-013 SHALL pass ps2_clk and ps2_data through 2-FF synchronizers, then a FILTER_LEN-sample glitch filter; filtered levels reset to 1.
REQ-014 SHALL sample data only on a filtered ps2_clk falling edge (filtered level 1->0).
REQ-015 SHALL run the frame FSM IDLE -> DATA -> PARITY -> STOP -> IDLE.
- IDLE: on an edge with data=0 go to DATA; on an edge with data=1 pulse frame_err and stay in IDLE.
- DATA: shift in 8 bits, LSB first; after the 8th edge go to PARITY.
- PARITY: capture the parity bit; go to STOP.
- STOP: on an edge, go to IDLE; the frame is good only if data=1 and the 8 data bits plus parity hold an odd number of ones.
REQ-016 SHALL, on a bad stop bit or bad parity, pulse frame_err for one cycle, discard the byte and leave the prefix flags unchanged.
REQ-017 SHALL keep a timeout counter:
- it clears on every falling edge and in IDLE;
- if it reaches TIMEOUT_CYCLES outside IDLE, the FSM returns to IDLE, frame_err pulses once and the partial byte is discarded.
REQ-018 SHALL handle good bytes as follows:
- 0xE0 sets ext_flag;
- 0xF0 sets brk_flag;
- any other byte is a terminal code and clears both flags in the same cycle.
REQ-019 SHALL act on a terminal code only when brk_flag=0 (a make code):
- key_valid pulses 1 cycle after the stop-bit edge is detected;
- key_code, key_letter, key_enter and key_bksp update in that same cycle and hold until the next make event.
REQ-020 SHALL emit no output pulse and change no output register for a break code (prefix F0).
REQ-021 SHALL set key_letter to 31 and key_enter and key_bksp to 0 when ext_flag=1 (extended keys are not letters).
REQ-022 SHALL map set-2 codes to letters: 1C=A, 32=B, 21=C, 23=D, 24=E, 2B=F, 34=G, 33=H, 43=I, 3B=J, 42=K, 4B=L, 3A=M, 31=N, 44=O, 4D=P, 15=Q, 2D=R, 1B=S, 2C=T, 3C=U, 2A=V, 1D=W, 22=X, 35=Y, 1A=Z; 5A=Enter; 66=Backspace.
REQ-023 SHALL emit a key_valid for every typematic repeat of a make code; no repeat suppression.
REQ-024 SHALL never pulse key_valid and frame_err in the same cycle.

Reset
REQ-025 SHALL, while clr_n=0 at a clk edge, set:
- FSM to IDLE;
- shift register, bit counter and timeout counter to 0;
- ext_flag and brk_flag to 0;
- filters to 1;
- key_valid=0, frame_err=0, key_code=0x00, key_letter=31, key_enter=0, key_bksp=0.
REQ-026 SHALL drop any frame in progress when reset is applied mid-frame; the first frame after reset is received normally.

Structure
REQ-027 SHALL place the frame FSM state encoding, the scan-code constants (E0, F0, 5A, 66) and the letter-lookup function in shared package ps2_pkg.
REQ-028 SHALL implement the synchronizer plus glitch filter as sub-module ps2_filter, instantiated twice (once for ps2_clk, once for ps2_data).

Verification
REQ-029 SHALL include test "make": frame 0x1C with odd parity, ps2_clk period 80 us -> one key_valid pulse, key_code=0x1C, key_letter=0.
REQ-030 SHALL include test "break": frames F0, 1C -> no key_valid; outputs keep their prior values; flags cleared.
REQ-031 SHALL include test "extended": frames E0, 5A -> key_valid=1, key_code=0x5A, key_enter=0, key_letter=31.
REQ-032 SHALL include test "parity error": frame 0x2D with wrong parity -> frame_err pulses once, no key_valid; the next frame 0x2D gives key_letter=17.
REQ-033 SHALL include test "timeout": ps2_clk stops after 4 data bits -> frame_err pulses once after 5000 cycles, FSM in IDLE; the next frame 0x66 gives key_bksp=1.
REQ-034 SHALL include test "glitch and reset": a 3-cycle low glitch on ps2_clk is ignored; clr_n=0 mid-frame returns all outputs to reset values.
